// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Arbitrates two requesters onto one shared, externally instantiated 8-bit ALU.
// Only one operation is in flight at a time. Requests are never queued: a
// requester that is not granted simply keeps (or drops) its valid.
//
// Ports
//   Clk, Rst                 clock, asynchronous active-high reset
//   reqN_valid/ready (N=0,1) request handshake (ready is combinational)
//   reqN_a, reqN_b, reqN_sel operands and opcode
//                            (0010 add, 0110 sub, 0000 and, 0001 or)
//   rsp_valid/rsp_ready      response handshake
//   rsp_id                   requester that issued the response
//   rsp_data, rsp_zero       ALU result and zero flag (zero comes from the ALU)
//   rsp_err                  opcode was illegal (ALU is not used)
//   alu_a, alu_b, alu_sel    drive to the shared ALU (sel=1111 means hold)
//   alu_out, alu_zero        ALU result, valid one posedge after alu_sel sampled
//
// DATA_W exists for interface symmetry; the shared ALU is 8 bits wide, so
// only DATA_W = 8 is supported.
//
// state   | meaning
// --------+------------------------------------------------------------------
// IDLE    | waiting for a request; ready driven for the granted requester
// ISSUE   | latched operands/opcode presented to the ALU for one cycle
// CAPTURE | ALU result valid; registered into the response this cycle
// RESP    | rsp_valid high, response held until rsp_ready
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_sel,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_sel,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err,

  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero
);

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_HOLD = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Requester granted most recently; reset to 1 so req0 wins the first tie.
  logic last_gnt;

  logic gnt_any;
  logic gnt_id;
  logic acc_legal;

  logic [DATA_W-1:0] acc_a;
  logic [DATA_W-1:0] acc_b;
  logic [3:0]        acc_sel;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [3:0]        op_sel;

  function automatic logic is_legal(input logic [3:0] sel);
    logic ok;
    ok = 1'b0;
    case (sel)
      OP_ADD, OP_SUB, OP_AND, OP_OR: ok = 1'b1;
      default:                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration: only in IDLE. A tie goes to the requester not granted last;
  // a lone request wins regardless of the pointer.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (state == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = ~last_gnt;
      end else if (req0_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b0;
      end else if (req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign req0_ready = gnt_any & ~gnt_id;
  assign req1_ready = gnt_any &  gnt_id;

  // Ready is only raised for a valid requester, so a grant is an acceptance.
  assign acc_a     = gnt_id ? req1_a   : req0_a;
  assign acc_b     = gnt_id ? req1_b   : req0_b;
  assign acc_sel   = gnt_id ? req1_sel : req0_sel;
  assign acc_legal = is_legal(acc_sel);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (gnt_any) begin
          // Illegal opcodes skip the ALU entirely.
          state_nxt = acc_legal ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE:   state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. The ALU sees operands only during ISSUE and is told to hold
  // otherwise, so it never computes on stale or illegal operations.
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_sel   = OP_HOLD;
    case (state)
      S_ISSUE: begin
        alu_a   = op_a;
        alu_b   = op_b;
        alu_sel = op_sel;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
      end
      default: begin
        rsp_valid = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operation latch, round-robin pointer and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      op_a     <= '0;
      op_b     <= '0;
      op_sel   <= OP_HOLD;
      last_gnt <= 1'b1;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      if (gnt_any) begin
        op_a     <= acc_a;
        op_b     <= acc_b;
        op_sel   <= acc_sel;
        last_gnt <= gnt_id;
        rsp_id   <= gnt_id;
        if (!acc_legal) begin
          rsp_err  <= 1'b1;
          rsp_data <= '0;
          rsp_zero <= 1'b0;
        end
      end
      if (state == S_CAPTURE) begin
        // Zero flag is taken from the ALU, not recomputed from the data.
        rsp_data <= alu_out;
        rsp_zero <= alu_zero;
        rsp_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed and randomized transactions against alu_arbiter, with a small
// behavioural model of the shared ALU attached to the ALU ports. Expected
// grants come from the round-robin rule tracked as "who was granted last";
// expected results come from plain modulo-256 arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_sel, req1_sel;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [7:0] rsp_data;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out  = 8'h00;
  logic       alu_zero = 1'b0;
  logic [7:0] alu_res;

  int checks   = 0;
  int errors   = 0;
  int last_gnt = 1;   // model: req0 favoured first

  always #5 Clk = ~Clk;

  alu_arbiter #(.DATA_W(8)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_sel  (req0_sel),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_sel  (req1_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero)
  );

  // Shared ALU model: samples sel on posedge, result valid after that edge.
  always @(posedge Clk) begin
    if (alu_sel != 4'b1111) begin
      case (alu_sel)
        4'b0010: alu_res = alu_a + alu_b;
        4'b0110: alu_res = alu_a - alu_b;
        4'b0000: alu_res = alu_a & alu_b;
        4'b0001: alu_res = alu_a | alu_b;
        default: alu_res = 8'h00;
      endcase
      alu_out  <= alu_res;
      alu_zero <= (alu_res == 8'h00);
    end
  end

  // Reference result; -1 marks an illegal opcode.
  function automatic int ref_result(input int a, input int b, input int sel);
    case (sel)
      2:       return (a + b) % 256;
      6:       return (a - b + 256) % 256;
      0:       return a & b;
      1:       return a | b;
      default: return -1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered and left just after a negedge. Drives a request pattern, checks
  // the grant, follows the operation to its response, optionally stalls the
  // response for 'hold' cycles, then completes the handshake.
  task automatic run_txn(input bit v0, input bit v1,
                         input int a0, input int b0, input int s0,
                         input int a1, input int b1, input int s1,
                         input int hold, input string tag);
    int  gid, a, b, s, res, lat;
    bit  legal;
    gid   = (v0 && v1) ? 1 - last_gnt : (v0 ? 0 : 1);
    a     = gid ? a1 : a0;
    b     = gid ? b1 : b0;
    s     = gid ? s1 : s0;
    res   = ref_result(a, b, s);
    legal = (res >= 0);
    lat   = legal ? 3 : 1;

    req0_valid = v0; req0_a = a0[7:0]; req0_b = b0[7:0]; req0_sel = s0[3:0];
    req1_valid = v1; req1_a = a1[7:0]; req1_b = b1[7:0]; req1_sel = s1[3:0];
    rsp_ready  = (hold == 0);
    #1;
    check({tag, ":ready0"}, req0_ready, gid == 0);
    check({tag, ":ready1"}, req1_ready, gid == 1);
    last_gnt = gid;
    @(posedge Clk);

    for (int k = 1; k <= lat; k++) begin
      @(negedge Clk);
      check({tag, ":rsp_valid_timing"}, rsp_valid, k == lat);
      check({tag, ":ready_busy"}, {req0_ready, req1_ready}, 2'b00);
      if (legal && k == 1) begin
        check({tag, ":alu_sel"}, alu_sel, s);
        check({tag, ":alu_a"}, alu_a, a);
        check({tag, ":alu_b"}, alu_b, b);
      end else begin
        check({tag, ":alu_hold"}, alu_sel, 4'b1111);
      end
    end
    check({tag, ":rsp_id"}, rsp_id, gid);
    check({tag, ":rsp_data"}, rsp_data, legal ? res : 0);
    check({tag, ":rsp_zero"}, rsp_zero, legal && (res == 0));
    check({tag, ":rsp_err"}, rsp_err, !legal);

    for (int h = 0; h < hold; h++) begin
      @(negedge Clk);
      check({tag, ":stall_valid"}, rsp_valid, 1'b1);
      check({tag, ":stall_data"}, {rsp_id, rsp_err, rsp_zero, rsp_data},
            {gid[0], !legal, legal && (res == 0), legal ? res[7:0] : 8'h00});
      check({tag, ":stall_ready"}, {req0_ready, req1_ready}, 2'b00);
    end

    rsp_ready = 1'b1;
    @(negedge Clk);
    check({tag, ":rsp_done"}, rsp_valid, 1'b0);
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    int v, r, s0, s1;
    int sel_tab[4];
    sel_tab[0] = 2; sel_tab[1] = 6; sel_tab[2] = 0; sel_tab[3] = 1;

    Rst = 1'b1;
    rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00; req0_sel = 4'h0;
    req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_sel = 4'h0;
    repeat (2) @(negedge Clk);
    check("reset:rsp", {rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_data}, 12'h000);
    check("reset:alu", {alu_sel, alu_a, alu_b}, {4'b1111, 16'h0000});
    check("reset:ready", {req0_ready, req1_ready}, 2'b00);
    Rst = 1'b0;
    @(negedge Clk);

    // Basic add, sub to zero, add with wrap.
    run_txn(1, 0, 8'h05, 8'h03, 2, 0, 0, 0, 0, "add_basic");
    run_txn(0, 1, 0, 0, 0, 8'h03, 8'h03, 6, 0, "sub_zero");
    run_txn(0, 1, 0, 0, 0, 8'hFF, 8'h01, 2, 0, "add_wrap");
    // Illegal opcode bypasses the ALU.
    run_txn(1, 0, 8'h12, 8'h34, 5, 0, 0, 0, 0, "illegal");
    idle_inputs();

    // Both held valid: grants must alternate.
    for (int i = 0; i < 4; i++)
      run_txn(1, 1, 8'h0F, 8'hF0, 1, 8'hAA, 8'h0F, 0, 0, $sformatf("rr%0d", i));

    // Stalled response with both requesters waiting.
    run_txn(1, 1, 8'h40, 8'h02, 6, 8'h11, 8'h22, 2, 5, "stall5");
    idle_inputs();

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      v  = $urandom_range(1, 3);
      r  = $urandom_range(0, 4);
      s0 = (r < 4) ? sel_tab[r] : $urandom_range(0, 15);
      r  = $urandom_range(0, 4);
      s1 = (r < 4) ? sel_tab[r] : $urandom_range(0, 15);
      run_txn(v[0], v[1], $urandom_range(0, 255), $urandom_range(0, 255), s0,
              $urandom_range(0, 255), $urandom_range(0, 255), s1,
              $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end
    idle_inputs();

    // Reset during CAPTURE drops the in-flight op.
    run_txn(0, 1, 0, 0, 0, 8'h10, 8'h20, 2, 0, "pre_rst");
    idle_inputs();
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_sel = 4'b0010;
    #1;
    check("rst_op:ready0", req0_ready, 1'b1);
    last_gnt = 0;
    @(posedge Clk);
    @(negedge Clk);
    req0_valid = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    check("rst_mid:rsp", {rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_data}, 12'h000);
    check("rst_mid:alu", {alu_sel, alu_a, alu_b}, {4'b1111, 16'h0000});
    last_gnt = 1;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("rst_mid:no_rsp", rsp_valid, 1'b0);
    end
    run_txn(1, 1, 8'h21, 8'h01, 6, 8'h07, 8'h08, 2, 0, "post_rst");
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
